// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the multicycle control FSM
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JALR, S_JUMP, S_BRANCH,
      S_LUI, S_AUIPC, S_ILLEGAL
   } state_e;

   // What kind of ALU operation the current state asks the decoder for
   typedef enum logic [1:0] {
      CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE
   } alu_class_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALUC_ADD  = 4'b0000;
   localparam logic [3:0] ALUC_SUB  = 4'b0001;
   localparam logic [3:0] ALUC_AND  = 4'b0010;
   localparam logic [3:0] ALUC_OR   = 4'b0011;
   localparam logic [3:0] ALUC_XOR  = 4'b0100;
   localparam logic [3:0] ALUC_SLT  = 4'b0101;
   localparam logic [3:0] ALUC_SLTU = 4'b0110;
   localparam logic [3:0] ALUC_SLL  = 4'b0111;
   localparam logic [3:0] ALUC_SRL  = 4'b1000;
   localparam logic [3:0] ALUC_SRA  = 4'b1001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMM       = 2'b11;

   // Branch condition from the SUB flags; CarryOut=1 means no borrow (a >= b unsigned)
   function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                         input logic carry, input logic ovf,
                                         input logic sign);
      logic taken;
      case (f3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = sign ^ ovf;
         3'b101:  taken = ~(sign ^ ovf);
         3'b110:  taken = ~carry;
         3'b111:  taken = carry;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - datapath <-> controller signal bundle
interface control_fsm_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        CarryOut;
   logic        Overflow;
   logic        Sign;
   logic        PCWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic        MemWrite;
   logic        AdrSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [2:0]  ImmSrc;
   logic [3:0]  ALUControl;
   logic        Illegal;

   // Datapath side: supplies instruction and flags, consumes controls
   modport master (
      output Instr, Zero, CarryOut, Overflow, Sign,
      input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, Illegal
   );

   // Controller side
   modport slave (
      input  Instr, Zero, CarryOut, Overflow, Sign,
      output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, Illegal
   );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps instruction fields and state class to ALUControl
module alu_decoder
   import control_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  alu_class_e alu_class,
   output logic [3:0] alu_control
);

   logic r_sub;

   // SUB only for register-register 000; immediate 000 is always ADD
   assign r_sub = (alu_class == CLS_RTYPE) & op[5] & funct7b5;

   // Select operation from class, then from funct3 for R/I instructions
   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_class)
         CLS_ADD: alu_control = ALUC_ADD;
         CLS_SUB: alu_control = ALUC_SUB;
         default: begin
            case (funct3)
               3'b000:  alu_control = r_sub ? ALUC_SUB : ALUC_ADD;
               3'b001:  alu_control = ALUC_SLL;
               3'b010:  alu_control = ALUC_SLT;
               3'b011:  alu_control = ALUC_SLTU;
               3'b100:  alu_control = ALUC_XOR;
               3'b101:  alu_control = funct7b5 ? ALUC_SRA : ALUC_SRL;
               3'b110:  alu_control = ALUC_OR;
               default: alu_control = ALUC_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV32I control unit (Moore FSM)
module control_fsm
   import control_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   control_fsm_if.slave bus
);

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       unused_instr;

   assign op           = bus.Instr[6:0];
   assign funct3       = bus.Instr[14:12];
   assign funct7b5     = bus.Instr[30];
   assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;

   logic       pc_write, ir_write, reg_write, mem_write, adr_src;
   logic [1:0] src_a, src_b, result_src;
   logic [2:0] imm_src;
   alu_class_e alu_class;
   logic [3:0] alu_control;

   alu_decoder u_alu_decoder (
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_class   (alu_class),
      .alu_control (alu_control)
   );

   // Next-state sequencing; Illegal latches once the FSM enters ILLEGAL
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_JAL:            state_d = S_JUMP;
               OP_JALR:           state_d = S_JALR;
               OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JALR:     state_d = S_JUMP;
         S_JUMP:     state_d = S_ALUWB;
         S_BRANCH:   state_d = S_FETCH;
         S_LUI:      state_d = S_FETCH;
         S_AUIPC:    state_d = S_ALUWB;
         default:    state_d = S_ILLEGAL;
      endcase
      illegal_d = illegal_q | (state_d == S_ILLEGAL);
   end

   // State register with synchronous reset back to FETCH
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Moore output decode from current state (and Instr fields)
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      src_a      = SRCA_PC;
      src_b      = SRCB_WD;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      alu_class  = CLS_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            src_b      = SRCB_FOUR;
            result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_IMM;
            imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEMADR: begin
            src_a   = SRCA_A;
            src_b   = SRCB_IMM;
            imm_src = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            src_a     = SRCA_A;
            alu_class = CLS_RTYPE;
         end
         S_EXECUTEI: begin
            src_a     = SRCA_A;
            src_b     = SRCB_IMM;
            alu_class = CLS_ITYPE;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_JALR: begin
            src_a = SRCA_A;
            src_b = SRCB_IMM;
         end
         S_JUMP: begin
            src_a    = SRCA_OLDPC;
            src_b    = SRCB_FOUR;
            pc_write = 1'b1;
         end
         S_BRANCH: begin
            src_a     = SRCA_A;
            alu_class = CLS_SUB;
            pc_write  = branch_taken(funct3, bus.Zero, bus.CarryOut, bus.Overflow, bus.Sign);
         end
         S_LUI: begin
            imm_src    = IMM_U;
            result_src = RES_IMM;
            reg_write  = 1'b1;
         end
         S_AUIPC: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_IMM;
            imm_src = IMM_U;
         end
         default: ;
      endcase
   end

   // Write strobes are forced low while reset is held, even mid-instruction
   assign bus.PCWrite    = pc_write  & ~rst;
   assign bus.IRWrite    = ir_write  & ~rst;
   assign bus.RegWrite   = reg_write & ~rst;
   assign bus.MemWrite   = mem_write & ~rst;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ImmSrc     = imm_src;
   assign bus.ALUControl = alu_control;
   assign bus.Illegal    = illegal_q;

endmodule
